// File: rtl/out_sram_pkg.sv
// Definitions shared by the output-SRAM readout blocks: state encoding and
// default geometry of the output banks.
package out_sram_pkg;

    localparam int OUT_DATA_WIDTH = 16;
    localparam int OUT_BANK_DEPTH = 2048;
    localparam int OUT_WORDS      = 2 * OUT_BANK_DEPTH;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        STREAM,
        DRAIN,
        GAP
    } state_t;

endpackage

// File: rtl/output_readout_scheduler_if.sv
// Bundle between the readout scheduler, the output SRAM banks and the
// shared output serializer.
interface output_readout_scheduler_if #(
    parameter int N_BANKS    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 13
);
    logic [N_BANKS-1:0]            req;
    logic                          abort;
    logic [N_BANKS-1:0]            bank_debug;
    logic [N_BANKS-1:0]            bank_read_trig;
    logic [N_BANKS*DATA_WIDTH-1:0] bank_rdata;
    logic                          ser_en;
    logic                          ser_deq;
    logic [DATA_WIDTH-1:0]         ser_pdata;
    logic [N_BANKS-1:0]            gnt;
    logic                          busy;
    logic                          done;
    logic                          aborted;
    logic [CNT_WIDTH-1:0]          word_cnt;

    // master is the scheduler; slave is everything around it.
    modport master (
        input  req, abort, bank_rdata, ser_deq,
        output bank_debug, bank_read_trig, ser_en, ser_pdata,
               gnt, busy, done, aborted, word_cnt
    );

    modport slave (
        output req, abort, bank_rdata, ser_deq,
        input  bank_debug, bank_read_trig, ser_en, ser_pdata,
               gnt, busy, done, aborted, word_cnt
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or
// after (ptr + 1) mod N, where ptr is the index granted last.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]                         req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
    input  logic                                 en,
    output logic [N-1:0]                         gnt
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW:0]    w_shift;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [2*N-1:0] w_back;

    assign w_shift = {1'b0, ptr} + (IW+1)'(1);

    // Rotate so the highest-priority request sits at bit 0, pick the lowest
    // set bit, then rotate the one-hot result back.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        w_rot  = '0;
        w_dbl  = {req, req} >> w_shift;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                w_rot    = '0;
                w_rot[i] = 1'b1;
            end
        end
        w_back = {{N{1'b0}}, w_rot} << w_shift;
        gnt    = en ? (w_back[N-1:0] | w_back[2*N-1:N]) : '0;
    end
endmodule

// File: rtl/output_readout_scheduler.sv
// Time-shares one output serializer between N output SRAM banks: round-robin
// grant, read-pipeline alignment, word counting, drain and inter-grant gap.
module output_readout_scheduler
    import out_sram_pkg::*;
#(
    parameter int N_BANKS    = 4,
    parameter int DATA_WIDTH = OUT_DATA_WIDTH,
    parameter int WORDS      = OUT_WORDS,
    parameter int CNT_WIDTH  = 13,
    parameter int ARM_CYCLES = 2,
    parameter int GAP_CYCLES = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output_readout_scheduler_if.master   bus
);
    localparam int IW    = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam int TMR_W = $clog2(DATA_WIDTH + ARM_CYCLES + GAP_CYCLES + 1);

    state_t                r_state;
    logic [N_BANKS-1:0]    r_gnt;
    logic [N_BANKS-1:0]    r_bank_debug;
    logic [IW-1:0]         r_gnt_idx;
    logic [IW-1:0]         r_last;
    logic [TMR_W-1:0]      r_tmr;
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic                  r_ser_en;
    logic                  r_done;
    logic                  r_aborted;

    logic [N_BANKS-1:0]    w_arb_gnt;
    logic [IW-1:0]         w_arb_idx;
    logic [DATA_WIDTH-1:0] w_pdata;
    logic                  w_abort;
    logic                  w_deq;
    logic                  w_last_word;

    rr_arbiter #(.N(N_BANKS)) u_arb (
        .req (bus.req),
        .ptr (r_last),
        .en  (r_state == IDLE),
        .gnt (w_arb_gnt)
    );

    always_comb begin
        w_arb_idx = '0;
        for (int i = 0; i < N_BANKS; i++)
            if (w_arb_gnt[i]) w_arb_idx = IW'(i);
    end

    always_comb begin
        w_pdata = '0;
        for (int i = 0; i < N_BANKS; i++)
            if (r_state != IDLE && r_gnt[i]) w_pdata = bus.bank_rdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // An abort cycle never forwards a strobe, so the word count freezes cleanly.
    assign w_abort     = bus.abort && (r_state inside {ARM, STREAM, DRAIN});
    assign w_deq       = bus.ser_deq && (r_state == STREAM) && !bus.abort;
    assign w_last_word = w_deq && (r_word_cnt == CNT_WIDTH'(WORDS - 1));

    assign bus.bank_read_trig = w_deq ? r_gnt : '0;
    assign bus.bank_debug     = r_bank_debug;
    assign bus.ser_en         = r_ser_en;
    assign bus.ser_pdata      = w_pdata;
    assign bus.gnt            = r_gnt;
    assign bus.busy           = (r_state != IDLE);
    assign bus.done           = r_done;
    assign bus.aborted        = r_aborted;
    assign bus.word_cnt       = r_word_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_bank_debug <= '0;
            r_gnt_idx    <= '0;
            r_last       <= IW'(N_BANKS - 1);
            r_tmr        <= '0;
            r_word_cnt   <= '0;
            r_ser_en     <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
            r_done <= 1'b0;
            if (w_abort) begin
                r_bank_debug <= '0;
                r_ser_en     <= 1'b0;
                r_aborted    <= 1'b1;
                r_tmr        <= '0;
                r_state      <= GAP;
            end else begin
                case (r_state)
                    IDLE: if (|bus.req) begin
                        r_gnt        <= w_arb_gnt;
                        r_gnt_idx    <= w_arb_idx;
                        r_bank_debug <= w_arb_gnt;
                        r_word_cnt   <= '0;
                        r_aborted    <= 1'b0;
                        r_tmr        <= '0;
                        r_state      <= ARM;
                    end
                    ARM: if (r_tmr == TMR_W'(ARM_CYCLES - 1)) begin
                        r_ser_en <= 1'b1;
                        r_tmr    <= '0;
                        r_state  <= STREAM;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                    STREAM: begin
                        if (w_deq) r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
                        if (w_last_word) begin
                            r_tmr   <= '0;
                            r_state <= DRAIN;
                        end
                    end
                    DRAIN: if (r_tmr == TMR_W'(DATA_WIDTH - 1)) begin
                        r_bank_debug <= '0;
                        r_ser_en     <= 1'b0;
                        r_tmr        <= '0;
                        r_state      <= GAP;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                    GAP: if (r_tmr == TMR_W'(GAP_CYCLES - 1)) begin
                        r_done  <= 1'b1;
                        r_gnt   <= '0;
                        r_last  <= r_gnt_idx;
                        r_tmr   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_tmr <= r_tmr + TMR_W'(1);
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_output_readout_scheduler.sv
// Directed sequence of grants with random bank contents and dequeue timing,
// checked against a grant-level model of the scheduler.
module tb_output_readout_scheduler;
    import out_sram_pkg::*;

    localparam int NB    = 4;
    localparam int DW    = OUT_DATA_WIDTH;
    localparam int WORDS = OUT_WORDS;
    localparam int CW    = 13;
    localparam int ARM   = 2;
    localparam int GAP   = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   checks     = 0;
    int   failures   = 0;
    int   low_cycles = 0;

    always #5 clk = ~clk;

    output_readout_scheduler_if #(.N_BANKS(NB), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    output_readout_scheduler #(
        .N_BANKS(NB), .DATA_WIDTH(DW), .WORDS(WORDS),
        .CNT_WIDTH(CW), .ARM_CYCLES(ARM), .GAP_CYCLES(GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Bank model: read address returns to 0 while debug is low, advances per trigger.
    logic [DW-1:0] mem [NB][WORDS];
    int            addr [NB];

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (!bus.bank_debug[b])         addr[b] <= 0;
            else if (bus.bank_read_trig[b]) addr[b] <= addr[b] + 1;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        assign bus.bank_rdata[b*DW +: DW] = mem[b][addr[b] % WORDS];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered on a negedge; returns on the negedge after the grant's done pulse.
    task automatic run_grant(input int bank, input bit cont, input int abort_at,
                             input bit chk_gap, input logic [NB-1:0] next_req);
        logic [NB-1:0] oh;
        int  waited, cyc, n_fwd, pulses, first_evt, last_evt;
        bit  deq, ab, fwd, ended, was_aborted;
        oh     = NB'(1) << bank;
        waited = 0;
        while (bus.bank_debug === '0 && waited < 64) begin
            low_cycles++;
            bus.ser_deq = cont;
            bus.abort   = 1'b0;
            @(negedge clk);
            waited++;
        end
        check("grant_wait_bounded", waited < 64, 1);
        if (chk_gap) check("debug_low_cycles", low_cycles >= GAP + 1, 1);
        check("gnt", bus.gnt, oh);
        check("bank_debug", bus.bank_debug, oh);
        check("word_cnt_start", bus.word_cnt, 0);
        check("busy", bus.busy, 1);
        low_cycles = 0;
        cyc = 0; n_fwd = 0; pulses = 0; first_evt = -1; last_evt = 0;
        ended = 0; was_aborted = 0;
        while (!ended && cyc < 8 * WORDS + 64) begin
            if (bus.bank_debug === '0) low_cycles++;
            if (cyc == ARM - 1) check("ser_en_before", bus.ser_en, 0);
            if (cyc == ARM)     check("ser_en_rise", bus.ser_en, 1);
            if (cyc == 10)      bus.req = next_req;
            if (bus.done === 1'b1) begin
                check("done_latency", cyc - last_evt, was_aborted ? GAP + 1 : 1 + DW + GAP);
                if (cont && !was_aborted)
                    check("done_from_first", cyc - first_evt, WORDS + DW + GAP);
                check("aborted", bus.aborted, was_aborted);
                check("trig_pulses", pulses, was_aborted ? abort_at : WORDS);
                check("word_cnt_final", bus.word_cnt, n_fwd);
                check("gnt_cleared", bus.gnt, 0);
                check("busy_cleared", bus.busy, 0);
                check("debug_cleared", bus.bank_debug, 0);
                check("ser_en_cleared", bus.ser_en, 0);
                ended = 1;
            end else begin
                ab  = (abort_at >= 0) && !was_aborted && (cyc >= ARM) && (n_fwd == abort_at);
                deq = cont ? 1'b1 : ($urandom_range(3) != 0);
                bus.abort   = ab;
                bus.ser_deq = deq;
                fwd = deq && !ab && !was_aborted && (cyc >= ARM) && (n_fwd < WORDS);
                #1;
                check("read_trig", bus.bank_read_trig, fwd ? oh : '0);
                if (bus.bank_read_trig[bank]) pulses++;
                if (fwd) begin
                    check("ser_pdata", bus.ser_pdata, mem[bank][n_fwd]);
                    check("word_cnt", bus.word_cnt, n_fwd);
                    if (first_evt < 0) first_evt = cyc;
                    last_evt = cyc;
                    n_fwd++;
                end
                if (ab) begin
                    was_aborted = 1;
                    last_evt    = cyc;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", ended, 1);
        bus.abort = 1'b0;
        @(negedge clk);
        check("done_pulse_width", bus.done, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited, n;
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < WORDS; w++)
                mem[b][w] = DW'($urandom);

        rst_n       = 1'b0;
        bus.req     = 4'b1111;
        bus.abort   = 1'b0;
        bus.ser_deq = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_bank_debug", bus.bank_debug, 0);
        check("rst_read_trig", bus.bank_read_trig, 0);
        check("rst_ser_en", bus.ser_en, 0);
        check("rst_ser_pdata", bus.ser_pdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_aborted", bus.aborted, 0);
        check("rst_word_cnt", bus.word_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("gnt_after_release", bus.gnt, 4'b0001);

        // Bank 0 first, then round-robin over banks 1 and 3.
        run_grant(0, 1'b0, -1, 1'b0, 4'b1010);
        run_grant(1, 1'b0, -1, 1'b1, 4'b1010);
        run_grant(3, 1'b1, -1, 1'b1, 4'b1010);
        run_grant(1, 1'b1, -1, 1'b1, 4'b0100);
        // Abort on bank 2, then a fresh grant of bank 2 from word 0.
        run_grant(2, 1'b1, 100, 1'b1, 4'b0100);
        run_grant(2, 1'b1, 5, 1'b1, 4'b1000);
        // Continuous dequeue with the request dropped mid-grant.
        run_grant(3, 1'b1, -1, 1'b1, 4'b0000);

        // Reset while streaming bank 0 at word 50.
        bus.req     = 4'b0001;
        bus.ser_deq = 1'b1;
        waited      = 0;
        while (bus.bank_debug !== 4'b0001 && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        n = 0;
        while (n < 50 && waited < 300) begin
            #1;
            if (bus.bank_read_trig[0]) n++;
            @(negedge clk);
            waited++;
        end
        check("word_cnt_before_kill", bus.word_cnt, 50);
        #2 rst_n = 1'b0;
        #1;
        check("kill_gnt", bus.gnt, 0);
        check("kill_bank_debug", bus.bank_debug, 0);
        check("kill_read_trig", bus.bank_read_trig, 0);
        check("kill_ser_en", bus.ser_en, 0);
        check("kill_ser_pdata", bus.ser_pdata, 0);
        check("kill_busy", bus.busy, 0);
        check("kill_word_cnt", bus.word_cnt, 0);
        check("kill_done", bus.done, 0);
        @(negedge clk);
        check("kill_done_held", bus.done, 0);
        rst_n = 1'b1;
        run_grant(0, 1'b1, -1, 1'b0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/output_readout_scheduler.md
Name: output_readout_scheduler

Overview:
Shares the single output serializer between N output SRAM interfaces, e.g. deconvolution kernel magnitude and phase banks. It grants one requesting bank at a time, round-robin, and drives that bank's debug enable. It forwards the serializer's dequeue strobe as the bank's debug_read_trig and muxes the bank's rdata onto the serializer's parallel input. It aligns the serializer enable with the bank's two-cycle read pipeline, counts words, drains the last word, then idles the bank so its read address resets before the next grant.

Parameters:
N_BANKS, 4, number of output SRAM interfaces sharing the serializer
DATA_WIDTH, 16, SRAM word width and serializer FETCH_WIDTH
WORDS, 4096, words streamed per grant (2*BANK_DEPTH)
CNT_WIDTH, 13, word counter width; must satisfy 2^CNT_WIDTH > WORDS
ARM_CYCLES, 2, delay from bank debug high to serializer enable
GAP_CYCLES, 3, idle cycles after a grant ends, for bank read-address reset and enable pipeline flush

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  N_BANKS  level request per bank: contents ready for readout
abort  in  1  single-cycle pulse; terminates the current grant early
bank_debug  out  N_BANKS  one-hot debug enable to each SRAM interface
bank_read_trig  out  N_BANKS  per-bank debug_read_trig
bank_rdata  in  N_BANKS*DATA_WIDTH  concatenated bank rdata; bank i at [i*DATA_WIDTH +: DATA_WIDTH]
ser_en  out  1  serializer en
ser_deq  in  1  serializer sender_deq (ready-for-next-word strobe)
ser_pdata  out  DATA_WIDTH  serializer parallel_data
gnt  out  N_BANKS  one-hot current grant; 0 when idle
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at the end of GAP
aborted  out  1  valid with done; 1 if the grant ended by abort
word_cnt  out  CNT_WIDTH  dequeue strobes accepted in the current grant

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0; ser_pdata=0. Round-robin pointer set so bank 0 has top priority.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise latch gnt = the first set req bit at or after (last granted index + 1) mod N_BANKS.
  - Set bank_debug=gnt and word_cnt=0, then go to ARM.
- ARM: hold bank_debug for ARM_CYCLES cycles. On the last ARM cycle, register ser_en=1 so that ser_en rises exactly ARM_CYCLES clocks after bank_debug. Then go to STREAM.
- STREAM:
  - bank_read_trig[g] = ser_deq, combinational; all other bank_read_trig bits are 0.
  - Each ser_deq=1 cycle increments word_cnt.
  - When ser_deq=1 and word_cnt==WORDS-1, go to DRAIN.
  - ser_deq after the WORDS-th strobe is never forwarded, so there is no over-read.
- DRAIN: count DATA_WIDTH cycles while the serializer shifts out the final word. bank_read_trig stays 0. Then, on the same edge, clear bank_debug and ser_en and go to GAP.
- GAP:
  - Wait GAP_CYCLES cycles with all bank controls low.
  - On the last GAP cycle, pulse done=1, clear gnt and busy, advance the round-robin pointer to the granted index, and go to IDLE.
- ser_pdata = bank_rdata slice selected by the registered grant index; 0 when idle.
- req changes are ignored outside IDLE; a bank dropping req mid-grant does not end its grant.
- abort:
  - In ARM, STREAM or DRAIN: next edge clears bank_debug and ser_en, sets aborted=1 and goes to GAP. word_cnt freezes.
  - In IDLE or GAP: ignored.
  - Coincident with the final ser_deq: abort wins and that strobe is not forwarded.
- Back-to-back grants: a new grant may start in the cycle after done. Minimum bank_debug low time is GAP_CYCLES+1 cycles.
- Single requester: the same bank is re-granted after each GAP.
- Reset mid-operation: immediate return to reset values. No done pulse.

Decomposition:
- Shared package out_sram_pkg holds:
  - state enum: IDLE, ARM, STREAM, DRAIN, GAP;
  - default constants OUT_DATA_WIDTH=16, OUT_BANK_DEPTH=2048, OUT_WORDS=4096.
- One sub-module, rr_arbiter: parameter N; inputs req, ptr, en; output one-hot gnt. It is combinational and reused by other shared-resource blocks.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> all outputs 0. After release, gnt=4'b0001 one cycle later. ser_en rises exactly 2 cycles after bank_debug[0].
- Full stream, bank 0 with WORDS=4096 and random words: the serialized bitstream matches the bank contents LSB-first.
  - bank_read_trig[0] pulses exactly 4096 times.
  - done pulses once, 4096 strobes + 16 drain + 3 gap cycles after the first strobe; aborted=0.
- Round-robin with req=4'b1010 held: grants go bank1, bank3, bank1. bank_debug stays low ≥4 cycles between grants. Each bank's data is read correctly.
- Abort at word_cnt=100 on bank 2: no further bank_read_trig[2]; done with aborted=1 after 3 gap cycles. The next grant of bank 2 restarts at word 0.
- Over-read guard: drive ser_deq high continuously -> exactly WORDS forwarded strobes. ser_deq during DRAIN/GAP is never seen on any bank_read_trig.
- Reset asserted during STREAM at word 50: outputs return to 0 asynchronously. After release with req=4'b0001, word_cnt restarts at 0 and no done pulse appears for the killed grant.
